trigger_csr_ctrl: RTL

//   Owns the Sdtrig CSR state (tselect/tdata1-3/tinfo/tcontrol/mcontext) and icount counters feeding

---
 rtl/trigger_csr_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/trigger_csr_ctrl.sv
// Sdtrig trigger CSR bank: tselect/tdata1-3/tinfo/tcontrol/mcontext, icount counters,
// hit-bit capture, breakpoint-exception pulse and the debug halt-request handshake.
module trigger_csr_ctrl #(
    parameter int NUM_TRIGGERS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          csr_we,
    input  logic [11:0]                   csr_addr,
    input  logic [31:0]                   csr_wdata,
    output logic [31:0]                   csr_rdata,
    input  logic                          instruction_retired,
    input  logic                          trap_taken,
    input  logic                          mret,
    input  logic                          debug_mode,
    input  logic [NUM_TRIGGERS-1:0]       trig_hit,
    input  logic                          trigger_fire,
    input  logic                          trigger_exception_req,
    output logic [1:0]                    tselect,
    output logic [NUM_TRIGGERS-1:0][31:0] tdata1,
    output logic [NUM_TRIGGERS-1:0][31:0] tdata2,
    output logic [NUM_TRIGGERS-1:0][31:0] tdata3,
    output logic [31:0]                   tcontrol,
    output logic [31:0]                   mcontext,
    output logic [NUM_TRIGGERS-1:0][31:0] icount_counter,
    output logic                          halt_req,
    output logic                          trig_exc_valid
);

    localparam logic [11:0] ADDR_TSELECT  = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1   = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2   = 12'h7A2;
    localparam logic [11:0] ADDR_TDATA3   = 12'h7A3;
    localparam logic [11:0] ADDR_TINFO    = 12'h7A4;
    localparam logic [11:0] ADDR_TCONTROL = 12'h7A5;
    localparam logic [11:0] ADDR_MCONTEXT = 12'h7A8;
    localparam logic [31:0] TINFO_VALUE   = 32'h0000_00FC;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HALT_REQ = 2'd1;
    localparam logic [1:0] S_IN_DEBUG = 2'd2;

    logic [1:0]                    state, state_next;
    logic                          mte, mpte;
    logic [NUM_TRIGGERS-1:0][13:0] count, count_next;
    logic [NUM_TRIGGERS-1:0][31:0] tdata1_next, tdata2_next, tdata3_next;
    logic                          slot_locked;
    logic [3:0]                    wtype;
    logic                          exc_next;

    function automatic logic [31:0] hit_mask(input logic [3:0] ttype);
        case (ttype)
            4'd2:             hit_mask = 32'h0010_0000;
            4'd3:             hit_mask = 32'h0100_0000;
            4'd4, 4'd5, 4'd7: hit_mask = 32'h0400_0000;
            4'd6:             hit_mask = 32'h0040_0000;
            default:          hit_mask = 32'h0000_0000;
        endcase
    endfunction

    // A slot claimed by the debugger (dmode=1) is read-only to M-mode software.
    assign slot_locked = tdata1[tselect][27] & ~debug_mode;
    assign wtype       = csr_wdata[31:28];

    always_comb begin
        // NOTE: every next-state signal takes a default before any conditional update, so no latch is inferred.
        tdata1_next = tdata1;
        tdata2_next = tdata2;
        tdata3_next = tdata3;
        count_next  = count;
        for (int i = 0; i < NUM_TRIGGERS; i++) begin
            if (trig_hit[i]) begin
                tdata1_next[i] = tdata1_next[i] | hit_mask(tdata1[i][31:28]);
            end
            if (instruction_retired && tdata1[i][31:28] == 4'd3 && tdata1[i][9] && mte &&
                !debug_mode && count[i] != 14'd0) begin
                count_next[i]         = count[i] - 14'd1;
                tdata1_next[i][23:10] = count[i] - 14'd1;
            end
        end
        // Software writes are applied last so they override hit and decrement updates.
        if (csr_we && !slot_locked) begin
            case (csr_addr)
                ADDR_TDATA1: begin
                    if (wtype >= 4'd2 && wtype <= 4'd7) begin
                        tdata1_next[tselect] = {csr_wdata[31:28],
                                                debug_mode ? csr_wdata[27] : tdata1[tselect][27],
                                                csr_wdata[26:0]};
                    end else begin
                        tdata1_next[tselect] = '0;
                    end
                    count_next[tselect] = (wtype == 4'd3) ? csr_wdata[23:10] : count[tselect];
                end
                ADDR_TDATA2: tdata2_next[tselect] = csr_wdata;
                ADDR_TDATA3: tdata3_next[tselect] = csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (trigger_fire && !debug_mode) state_next = S_HALT_REQ;
            S_HALT_REQ: if (debug_mode) state_next = S_IN_DEBUG;
            S_IN_DEBUG: if (!debug_mode) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // A halt request takes priority over a breakpoint exception raised in the same cycle.
    assign exc_next = trigger_exception_req & ~debug_mode & (state == S_IDLE) & ~trigger_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-slot trigger arrays are reset along with everything else so no trigger can match out of reset.
            tselect        <= '0;
            tdata1         <= '0;
            tdata2         <= '0;
            tdata3         <= '0;
            count          <= '0;
            mte            <= 1'b0;
            mpte           <= 1'b0;
            mcontext       <= '0;
            state          <= S_IDLE;
            trig_exc_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on this cycle's values.
            tdata1         <= tdata1_next;
            tdata2         <= tdata2_next;
            tdata3         <= tdata3_next;
            count          <= count_next;
            state          <= state_next;
            trig_exc_valid <= exc_next;
            if (csr_we && csr_addr == ADDR_TSELECT && csr_wdata < 32'(NUM_TRIGGERS)) begin
                tselect <= csr_wdata[1:0];
            end
            if (csr_we && csr_addr == ADDR_MCONTEXT) begin
                mcontext <= csr_wdata;
            end
            if (trap_taken) begin
                mpte <= mte;
                mte  <= 1'b0;
            end else if (mret) begin
                mte <= mpte;
            end else if (csr_we && csr_addr == ADDR_TCONTROL) begin
                mte  <= csr_wdata[3];
                mpte <= csr_wdata[7];
            end
        end
    end

    assign tcontrol = {24'd0, mpte, 3'd0, mte, 3'd0};
    assign halt_req = (state == S_HALT_REQ);

    for (genvar g = 0; g < NUM_TRIGGERS; g++) begin : g_count
        assign icount_counter[g] = {18'd0, count[g]};
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_TSELECT:  csr_rdata = {30'd0, tselect};
            ADDR_TDATA1:   csr_rdata = tdata1[tselect];
            ADDR_TDATA2:   csr_rdata = tdata2[tselect];
            ADDR_TDATA3:   csr_rdata = tdata3[tselect];
            ADDR_TINFO:    csr_rdata = TINFO_VALUE;
            ADDR_TCONTROL: csr_rdata = tcontrol;
            ADDR_MCONTEXT: csr_rdata = mcontext;
            default:       csr_rdata = '0;
        endcase
    end

endmodule
